cve2_ex_seq_ctrl: RTL and testbench
===================================

Name: cve2_ex_seq_ctrl

Overview:
Issue-side sequencer for the execute stage. It accepts one decoded instruction at a time and drives the dynamic mult/div enables and the ALU first-cycle flag. It owns the two 34-bit intermediate-value registers that EX writes through imd_val_we/imd_val_d, including the MAC accumulator in register 0. It waits for ex_valid, then holds the result in a writeback register until the consumer accepts it.

Parameters:
MacCycles, 2, cycles a MAC occupies EX; ex_valid_i ignored before the last one (legal 1..8)
MaxCycles, 40, EXEC watchdog limit in cycles (legal MacCycles..63)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
issue_valid_i  in  1  decoded instruction offered
issue_ready_o  out  1  sequencer can accept
mult_sel_i  in  1  static: instruction is MUL*, sampled at accept
div_sel_i  in  1  static: instruction is DIV/REM, sampled at accept
mac_sel_i  in  1  static: instruction is MAC, sampled at accept
mac_acc_clr_i  in  1  clear accumulator (imd reg 0); honoured in IDLE only
kill_i  in  1  flush current operation
mult_en_o  out  1  dynamic multiply enable to EX
div_en_o  out  1  dynamic divide enable to EX
alu_instr_first_cycle_o  out  1  first EXEC cycle flag to EX
imd_val_we_i  in  2  per-register write enable from EX
imd_val_d_i  in  2x34  write data from EX
imd_val_q_o  out  2x34  intermediate registers to EX
ex_valid_i  in  1  EX result valid
result_ex_i  in  32  EX result
wb_valid_o  out  1  writeback data valid
wb_data_o  out  32  writeback data
wb_ready_i  in  1  writeback consumer accepts
busy_o  out  1  state != IDLE
timeout_o  out  1  one-cycle pulse on watchdog expiry

Behaviour:
- Reset values:
  - state=IDLE, issue_ready_o=1.
  - All other outputs 0; imd regs 0; cycle counter 0.
- FSM states: IDLE, EXEC, WB.
  - IDLE: issue_ready_o=1. On issue_valid_i & ~kill_i: latch mult/div/mac sel, clear counter, go to EXEC.
  - EXEC: mult_en_o=mult_q&~kill_i and div_en_o=div_q&~kill_i, both combinational. alu_instr_first_cycle_o=1 only when counter==0. The counter increments each cycle and saturates at 63.
  - EXEC completion: qualified done = ex_valid_i & (~mac_q | counter>=MacCycles-1). On done: wb_data<=result_ex_i and go to WB.
  - EXEC timeout: if counter==MaxCycles-1 and not done, pulse timeout_o and go to IDLE. No writeback.
  - WB: wb_valid_o=1 with wb_data stable. On wb_ready_i go to IDLE. issue_ready_o=0 in WB, so there is no back-to-back issue.
- Latency: accept at cycle N; earliest EXEC cycle is N+1; earliest wb_valid_o is N+2.
- kill_i, any state: go to IDLE next cycle.
  - Enables are deasserted in the same cycle.
  - No imd write that cycle; wb_valid_o drops next cycle; no timeout pulse.
  - kill_i in IDLE blocks acceptance.
- Intermediate register writes, in priority order:
  1. kill_i: no write.
  2. MAC done in EXEC: imd0 <= {2'b0, result_ex_i}. An imd_val_we_i[0] in the same cycle is ignored; imd1 still follows we[1].
  3. EXEC and imd_val_we_i[k]: immkk <= imd_val_d_i[k].
  4. IDLE and mac_acc_clr_i & ~issue accept: imd0 <= 0.
- imd_val_we_i is ignored outside EXEC.
- mac_acc_clr_i coincident with an accepted issue: the clear is dropped and the accept wins.
- imd1 is not touched by MAC or clear.
- Asynchronous reset mid-operation returns everything to reset values immediately.

Test Plan:
1. ALU op: issue at cycle 0, ex_valid_i=1 with result 0x0000_0042 in the first EXEC cycle → alu_instr_first_cycle_o=1 at cycle 1; wb_valid_o=1 with 0x42 at cycle 2; wb_ready_i held low 3 cycles → data stable; then IDLE.
2. MAC, MacCycles=2, imd0=5: issue MAC, ex_valid_i=1 from the first EXEC cycle with result 0x0000_0011 → ignored in the first cycle, accepted in the second; wb_data=0x11; imd0=0x0_0000_0011.
3. DIV taking 35 cycles: div_en_o high for exactly 35 EXEC cycles; EX writes imd_val_we_i=2'b11 each cycle → imd regs track imd_val_d_i; then ex_valid_i → WB.
4. Watchdog, MaxCycles=40: MUL issued, ex_valid_i never asserted → timeout_o single pulse on the 40th EXEC cycle; no wb_valid_o; next cycle issue_ready_o=1.
5. Kill mid-DIV at EXEC cycle 10 with imd_val_we_i=2'b01 → mult_en_o and div_en_o drop that cycle; imd0 unchanged; IDLE next cycle; no writeback.
6. Accumulator clear: imd0=0x3_FFFF_FFFF, mac_acc_clr_i in IDLE → imd0=0. Then clear plus issue_valid_i in the same cycle → issue accepted and imd0 not cleared.

Source files
------------

// File: rtl/cve2_ex_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cve2_ex_seq_ctrl
// Brief    : Execute-stage issue sequencer. Accepts one decoded instruction,
//            drives the dynamic mult/div enables and ALU first-cycle flag,
//            owns the two 34-bit intermediate registers (MAC accumulator in
//            register 0), waits for EX completion and holds the result until
//            the writeback consumer takes it.
// Revision : 1.0  initial release
// ============================================================================
module cve2_ex_seq_ctrl #(
    parameter int MAC_CYCLES = 2,   // EX occupancy of a MAC, 1..8
    parameter int MAX_CYCLES = 40   // EXEC watchdog limit, MAC_CYCLES..63
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        issue_valid_i,
    output logic        issue_ready_o,
    input  logic        mult_sel_i,
    input  logic        div_sel_i,
    input  logic        mac_sel_i,
    input  logic        mac_acc_clr_i,
    input  logic        kill_i,
    output logic        mult_en_o,
    output logic        div_en_o,
    output logic        alu_instr_first_cycle_o,
    input  logic [1:0]  imd_val_we_i,
    input  logic [67:0] imd_val_d_i,    // {reg1, reg0}, 34 bits each
    output logic [67:0] imd_val_q_o,    // {reg1, reg0}, 34 bits each
    input  logic        ex_valid_i,
    input  logic [31:0] result_ex_i,
    output logic        wb_valid_o,
    output logic [31:0] wb_data_o,
    input  logic        wb_ready_i,
    output logic        busy_o,
    output logic        timeout_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_t;

    localparam logic [5:0] c_MAC_LAST = 6'(MAC_CYCLES - 1);
    localparam logic [5:0] c_MAX_LAST = 6'(MAX_CYCLES - 1);
    localparam logic [5:0] c_CNT_SAT  = 6'd63;

    state_t      r_state;
    logic [5:0]  r_cnt;
    logic        r_mult_q;
    logic        r_div_q;
    logic        r_mac_q;
    logic        r_issue_ready;
    logic        r_busy;
    logic        r_wb_valid;
    logic [31:0] r_wb_data;
    logic [33:0] r_imd0;
    logic [33:0] r_imd1;

    logic        w_in_exec;
    logic        w_accept;
    logic        w_done;
    logic        w_mac_done;
    logic        w_timeout;

    assign w_in_exec  = (r_state == S_EXEC);
    assign w_accept   = (r_state == S_IDLE) & issue_valid_i & ~kill_i;
    // A MAC result is only meaningful once the MAC has occupied EX long enough.
    assign w_done     = w_in_exec & ex_valid_i & (~r_mac_q | (r_cnt >= c_MAC_LAST));
    assign w_mac_done = w_done & r_mac_q;
    assign w_timeout  = w_in_exec & ~kill_i & ~w_done & (r_cnt == c_MAX_LAST);

    assign issue_ready_o           = r_issue_ready;
    assign busy_o                  = r_busy;
    assign wb_valid_o              = r_wb_valid;
    assign wb_data_o               = r_wb_data;
    assign mult_en_o               = w_in_exec & r_mult_q & ~kill_i;
    assign div_en_o                = w_in_exec & r_div_q & ~kill_i;
    assign alu_instr_first_cycle_o = w_in_exec & (r_cnt == 6'd0);
    assign timeout_o               = w_timeout;
    assign imd_val_q_o             = {r_imd1, r_imd0};

    // Sequencer FSM with registered handshake/status outputs and cycle counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state       <= S_IDLE;
            r_cnt         <= 6'd0;
            r_mult_q      <= 1'b0;
            r_div_q       <= 1'b0;
            r_mac_q       <= 1'b0;
            r_issue_ready <= 1'b1;
            r_busy        <= 1'b0;
            r_wb_valid    <= 1'b0;
            r_wb_data     <= 32'd0;
        end else if (kill_i) begin
            r_state       <= S_IDLE;
            r_issue_ready <= 1'b1;
            r_busy        <= 1'b0;
            r_wb_valid    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (issue_valid_i) begin
                        r_mult_q      <= mult_sel_i;
                        r_div_q       <= div_sel_i;
                        r_mac_q       <= mac_sel_i;
                        r_cnt         <= 6'd0;
                        r_state       <= S_EXEC;
                        r_issue_ready <= 1'b0;
                        r_busy        <= 1'b1;
                    end
                end
                S_EXEC: begin
                    if (r_cnt != c_CNT_SAT) begin
                        r_cnt <= r_cnt + 6'd1;
                    end
                    if (w_done) begin
                        r_wb_data  <= result_ex_i;
                        r_wb_valid <= 1'b1;
                        r_state    <= S_WB;
                    end else if (r_cnt == c_MAX_LAST) begin
                        r_state       <= S_IDLE;
                        r_issue_ready <= 1'b1;
                        r_busy        <= 1'b0;
                    end
                end
                S_WB: begin
                    if (wb_ready_i) begin
                        r_wb_valid    <= 1'b0;
                        r_state       <= S_IDLE;
                        r_issue_ready <= 1'b1;
                        r_busy        <= 1'b0;
                    end
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_issue_ready <= 1'b1;
                    r_busy        <= 1'b0;
                    r_wb_valid    <= 1'b0;
                end
            endcase
        end
    end

    // Intermediate registers: MAC result beats EX write to reg 0; clear only when idle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_imd0 <= 34'd0;
            r_imd1 <= 34'd0;
        end else if (!kill_i) begin
            if (w_in_exec) begin
                if (w_mac_done) begin
                    r_imd0 <= {2'b00, result_ex_i};
                end else if (imd_val_we_i[0]) begin
                    r_imd0 <= imd_val_d_i[33:0];
                end
                if (imd_val_we_i[1]) begin
                    r_imd1 <= imd_val_d_i[67:34];
                end
            end else if ((r_state == S_IDLE) && mac_acc_clr_i && !w_accept) begin
                r_imd0 <= 34'd0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cve2_ex_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cve2_ex_seq_ctrl
// Brief    : Self-checking bench for cve2_ex_seq_ctrl: vector table for the
//            single-cycle handshake behaviour plus directed multi-cycle
//            sequences (MAC, long DIV, watchdog, kill, accumulator clear,
//            asynchronous reset).
// Revision : 1.0  initial release
// ============================================================================
module tb_cve2_ex_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        issue_valid, issue_ready;
    logic        mult_sel, div_sel, mac_sel, mac_clr, kill;
    logic        mult_en, div_en, first;
    logic [1:0]  imd_we;
    logic [67:0] imd_d, imd_q;
    logic        ex_valid;
    logic [31:0] result;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic        wb_ready, busy, timeout;

    int n_pass = 0;
    int n_total = 0;
    logic [33:0] e0, e1;

    cve2_ex_seq_ctrl #(.MAC_CYCLES(2), .MAX_CYCLES(40)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .issue_valid_i(issue_valid), .issue_ready_o(issue_ready),
        .mult_sel_i(mult_sel), .div_sel_i(div_sel), .mac_sel_i(mac_sel),
        .mac_acc_clr_i(mac_clr), .kill_i(kill),
        .mult_en_o(mult_en), .div_en_o(div_en), .alu_instr_first_cycle_o(first),
        .imd_val_we_i(imd_we), .imd_val_d_i(imd_d), .imd_val_q_o(imd_q),
        .ex_valid_i(ex_valid), .result_ex_i(result),
        .wb_valid_o(wb_valid), .wb_data_o(wb_data), .wb_ready_i(wb_ready),
        .busy_o(busy), .timeout_o(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv, mul, dv, mac, kl, exv;
        logic [31:0] res;
        logic        wbr;
        logic        e_rdy, e_mul, e_div, e_first, e_wbv, e_busy, e_to;
        logic [31:0] e_data;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic iv, logic mul, logic dv, logic mac, logic kl,
                                logic exv, logic [31:0] res, logic wbr,
                                logic e_rdy, logic e_mul, logic e_div, logic e_first,
                                logic e_wbv, logic e_busy, logic e_to, logic [31:0] e_data);
        vec_t v;
        v.iv = iv; v.mul = mul; v.dv = dv; v.mac = mac; v.kl = kl; v.exv = exv;
        v.res = res; v.wbr = wbr; v.e_rdy = e_rdy; v.e_mul = e_mul; v.e_div = e_div;
        v.e_first = e_first; v.e_wbv = e_wbv; v.e_busy = e_busy; v.e_to = e_to;
        v.e_data = e_data;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [67:0] act, input logic [67:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        issue_valid = 0; mult_sel = 0; div_sel = 0; mac_sel = 0; mac_clr = 0;
        kill = 0; imd_we = 2'b00; imd_d = '0; ex_valid = 0; result = '0; wb_ready = 0;
    endtask

    // Load imd registers through a plain ALU op (starts and ends in IDLE).
    task automatic load_imd(input logic [1:0] we, input logic [33:0] d0, input logic [33:0] d1);
        issue_valid = 1; cyc(); issue_valid = 0;
        imd_we = we; imd_d = {d1, d0}; ex_valid = 1; result = 32'h0; cyc();
        imd_we = 2'b00; ex_valid = 0; wb_ready = 1; cyc(); wb_ready = 0;
    endtask

    initial begin
        idle_inputs();
        rst_n = 0;
        e0 = '0; e1 = '0;
        @(posedge clk); @(posedge clk); #1;
        chk("reset_ready", {67'd0, issue_ready}, 68'd1);
        chk("reset_outs", {62'd0, busy, wb_valid, mult_en, div_en, first, timeout}, 68'd0);
        chk("reset_imd", imd_q, 68'd0);
        chk("reset_wbdata", {36'd0, wb_data}, 68'd0);
        rst_n = 1;
        cyc();

        // ---------------- table-driven vectors ----------------
        //                iv mul dv mac kl exv res           wbr rdy mul div fst wbv bsy to data
        vq.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0,        0,  1,  0,  0,  0,  0,  0,  0, 32'h0));
        vq.push_back(mk(0, 0, 0, 0, 0, 1, 32'h42,       0,  0,  0,  0,  1,  0,  1,  0, 32'h0));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        0,  0,  0,  0,  0,  1,  1,  0, 32'h42));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        0,  0,  0,  0,  0,  1,  1,  0, 32'h42));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        0,  0,  0,  0,  0,  1,  1,  0, 32'h42));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        1,  0,  0,  0,  0,  1,  1,  0, 32'h42));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        0,  1,  0,  0,  0,  0,  0,  0, 32'h0));
        // MUL killed in second EXEC cycle
        vq.push_back(mk(1, 1, 0, 0, 0, 0, 32'h0,        0,  1,  0,  0,  0,  0,  0,  0, 32'h0));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        0,  0,  1,  0,  1,  0,  1,  0, 32'h0));
        vq.push_back(mk(0, 0, 0, 0, 1, 0, 32'h0,        0,  0,  0,  0,  0,  0,  1,  0, 32'h0));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        0,  1,  0,  0,  0,  0,  0,  0, 32'h0));
        // kill in IDLE blocks acceptance
        vq.push_back(mk(1, 0, 0, 0, 1, 0, 32'h0,        0,  1,  0,  0,  0,  0,  0,  0, 32'h0));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        0,  1,  0,  0,  0,  0,  0,  0, 32'h0));
        // DIV done in first cycle, then killed while in WB
        vq.push_back(mk(1, 0, 1, 0, 0, 0, 32'h0,        0,  1,  0,  0,  0,  0,  0,  0, 32'h0));
        vq.push_back(mk(0, 0, 0, 0, 0, 1, 32'hCAFEF00D, 0,  0,  0,  1,  1,  0,  1,  0, 32'h0));
        vq.push_back(mk(0, 0, 0, 0, 1, 0, 32'h0,        0,  0,  0,  0,  0,  1,  1,  0, 32'hCAFEF00D));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        0,  1,  0,  0,  0,  0,  0,  0, 32'h0));

        foreach (vq[i]) begin
            issue_valid = vq[i].iv; mult_sel = vq[i].mul; div_sel = vq[i].dv;
            mac_sel = vq[i].mac; kill = vq[i].kl; ex_valid = vq[i].exv;
            result = vq[i].res; wb_ready = vq[i].wbr;
            #1;
            chk($sformatf("vec%0d_ctl", i),
                {61'd0, issue_ready, mult_en, div_en, first, wb_valid, busy, timeout},
                {61'd0, vq[i].e_rdy, vq[i].e_mul, vq[i].e_div, vq[i].e_first,
                 vq[i].e_wbv, vq[i].e_busy, vq[i].e_to});
            if (vq[i].e_wbv)
                chk($sformatf("vec%0d_data", i), {36'd0, wb_data}, {36'd0, vq[i].e_data});
            cyc();
        end
        idle_inputs();
        chk("table_imd_untouched", imd_q, 68'd0);

        // ---------------- MAC with accumulator ----------------
        load_imd(2'b01, 34'd5, 34'd0);
        e0 = 34'd5;
        chk("mac_pre_imd", imd_q, {e1, e0});
        issue_valid = 1; mac_sel = 1; cyc(); issue_valid = 0; mac_sel = 0;
        ex_valid = 1; result = 32'h11; #1;
        chk("mac_first", {67'd0, first}, 68'd1);
        cyc();
        chk("mac_early_ignored", {66'd0, wb_valid, busy}, 68'b01);
        chk("mac_imd_hold", imd_q, {e1, e0});
        imd_we = 2'b11; imd_d = {34'h1_2345_6789, 34'h3_0000_0000}; cyc();
        imd_we = 2'b00; ex_valid = 0;
        e0 = 34'h0_0000_0011; e1 = 34'h1_2345_6789;
        chk("mac_wb", {35'd0, wb_valid, wb_data}, {35'd0, 1'b1, 32'h11});
        chk("mac_imd", imd_q, {e1, e0});
        wb_ready = 1; cyc(); wb_ready = 0;

        // ---------------- DIV taking 35 cycles ----------------
        issue_valid = 1; div_sel = 1; cyc(); issue_valid = 0; div_sel = 0;
        for (int i = 0; i < 35; i++) begin
            imd_we = 2'b11;
            e0 = {2'(i), 32'(i * 7 + 1)};
            e1 = {2'(i + 1), 32'(32'hA000_0000 + i)};
            imd_d = {e1, e0};
            ex_valid = (i == 34); result = 32'h35;
            #1;
            chk($sformatf("div_en_c%0d", i), {67'd0, div_en}, 68'd1);
            cyc();
            chk($sformatf("div_imd_c%0d", i), imd_q, {e1, e0});
        end
        imd_we = 2'b00; ex_valid = 0;
        chk("div_wb", {33'd0, div_en, wb_valid, wb_data}, {33'd0, 1'b0, 1'b1, 32'h35});
        wb_ready = 1; cyc(); wb_ready = 0;

        // ---------------- kill mid-DIV at EXEC cycle 10 ----------------
        issue_valid = 1; div_sel = 1; cyc(); issue_valid = 0; div_sel = 0;
        for (int i = 1; i < 10; i++) cyc();
        kill = 1; imd_we = 2'b01; imd_d = {34'h0, 34'h0_0000_DEAD}; #1;
        chk("kill_en", {65'd0, mult_en, div_en, timeout}, 68'd0);
        cyc();
        kill = 0; imd_we = 2'b00;
        chk("kill_imd", imd_q, {e1, e0});
        chk("kill_idle", {65'd0, issue_ready, busy, wb_valid}, 68'b100);

        // ---------------- watchdog on MUL ----------------
        issue_valid = 1; mult_sel = 1; cyc(); issue_valid = 0; mult_sel = 0;
        for (int i = 1; i <= 40; i++) begin
            #1;
            chk($sformatf("wd_c%0d", i), {65'd0, timeout, wb_valid, mult_en},
                {65'd0, (i == 40), 1'b0, 1'b1});
            cyc();
        end
        chk("wd_after", {65'd0, issue_ready, busy, timeout, wb_valid}, 68'b1000);

        // ---------------- accumulator clear ----------------
        load_imd(2'b01, 34'h3_FFFF_FFFF, 34'h0);
        e0 = 34'h3_FFFF_FFFF;
        chk("clr_pre", imd_q, {e1, e0});
        mac_clr = 1; cyc(); mac_clr = 0;
        e0 = 34'd0;
        chk("clr_idle", imd_q, {e1, e0});
        load_imd(2'b01, 34'h1_0000_0001, 34'h0);
        e0 = 34'h1_0000_0001;
        mac_clr = 1; issue_valid = 1; cyc(); mac_clr = 0; issue_valid = 0;
        chk("clr_accept_busy", {66'd0, busy, issue_ready}, 68'b10);
        chk("clr_dropped", imd_q, {e1, e0});

        // ---------------- asynchronous reset mid-operation ----------------
        #3 rst_n = 0;
        #1;
        chk("arst_ctl", {65'd0, issue_ready, busy, wb_valid}, 68'b100);
        chk("arst_imd", imd_q, 68'd0);
        cyc();
        rst_n = 1;
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
